// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: state encoding, timeout default
// and the special-case result constants.
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4,
    ST_DRAIN     = 3'd5
  } state_t;

  localparam int          TIMEOUT_DEF = 63;
  localparam int          CNT_W       = 6;
  localparam logic [31:0] ALL_ONES    = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN     = 32'h8000_0000;

  // Signed INT_MIN / -1 cannot be represented, so it bypasses the divider.
  function automatic logic is_overflow(input logic sgn, input logic [31:0] a,
                                       input logic [31:0] b);
    return sgn && (a == INT_MIN) && (b == ALL_ONES);
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequencer between the pipeline and an iterative divider: captures DIV/DIVU
// operands, handles divide-by-zero and overflow locally, and guards against a hung divider.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_symbol,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        err_timeout
);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_signed;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               w_capture;
  logic               w_bypass;
  logic               w_timeout;
  logic               w_active;

  assign w_capture = (r_state == ST_IDLE) && req_valid && !flush;
  assign w_bypass  = (req_b == 32'd0) || is_overflow(req_signed, req_a, req_b);
  assign w_active  = (r_state == ST_WAIT_BUSY) || (r_state == ST_RUN);
  assign w_timeout = w_active && (r_cnt == CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; flush outranks timeout, timeout outranks normal progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_next = w_bypass ? ST_DONE : ST_START;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (flush) begin
          w_next = ST_DRAIN;
        end else begin
          w_next = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (flush || w_timeout) begin
          w_next = ST_DRAIN;
        end else if (div_busy) begin
          w_next = ST_RUN;
        end else begin
          w_next = ST_WAIT_BUSY;
        end
      end
      ST_RUN: begin
        if (flush || w_timeout) begin
          w_next = ST_DRAIN;
        end else if (!div_busy) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_DRAIN: begin
        if (!div_busy) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_DRAIN;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand capture and HI/LO result registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_signed <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (w_capture) begin
      r_a      <= req_a;
      r_b      <= req_b;
      r_signed <= req_signed;
      if (req_b == 32'd0) begin
        r_hi <= req_a;
        r_lo <= ALL_ONES;
      end else if (is_overflow(req_signed, req_a, req_b)) begin
        r_hi <= 32'd0;
        r_lo <= INT_MIN;
      end
    end else if ((r_state == ST_RUN) && (w_next == ST_DONE)) begin
      r_hi <= div_r;
      r_lo <= div_q;
    end
  end

  // Watchdog counter over WAIT_BUSY/RUN and the sticky timeout flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= {CNT_W{1'b0}};
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_START) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_active) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Output decode; stall is forced low while reset is asserted.
  always_comb begin
    stall     = 1'b0;
    res_valid = 1'b0;
    div_start = 1'b0;
    case (r_state)
      ST_IDLE:      stall = w_capture;
      ST_START: begin
        stall     = 1'b1;
        div_start = 1'b1;
      end
      ST_WAIT_BUSY: stall = 1'b1;
      ST_RUN:       stall = 1'b1;
      ST_DRAIN:     stall = 1'b1;
      ST_DONE:      res_valid = !flush;
      default: begin
        stall     = 1'b0;
        res_valid = 1'b0;
        div_start = 1'b0;
      end
    endcase
    if (!resetn) begin
      stall = 1'b0;
    end else begin
      stall = stall;
    end
  end

  assign res_hi      = r_hi;
  assign res_lo      = r_lo;
  assign div_a       = r_a;
  assign div_b       = r_b;
  assign div_symbol  = r_signed;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural divider stub and a
// high-level arithmetic reference model.
module tb_div_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid, req_signed, flush;
  logic [31:0] req_a, req_b;
  logic        stall, res_valid, div_start, div_symbol, err_timeout;
  logic [31:0] res_hi, res_lo, div_a, div_b;
  logic        div_busy;
  logic [31:0] div_q, div_r;

  div_ctrl dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
    .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_symbol(div_symbol),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   fall_cyc = -10;
  logic prev_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider stub: sign-magnitude long division, configurable delay/length/hang.
  int          cfg_dly = 0, cfg_len = 2;
  bit          hang = 1'b0;
  logic [31:0] sa, sb;
  logic        ss;
  int          st_dly, st_left;
  bit          st_arm;
  logic [31:0] ma, mb, qm, rm;
  always_comb begin
    ma = (ss && sa[31]) ? -sa : sa;
    mb = (ss && sb[31]) ? -sb : sb;
    qm = (mb != 32'd0) ? ma / mb : 32'd0;
    rm = (mb != 32'd0) ? ma % mb : 32'd0;
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_busy <= 1'b0; div_q <= 32'd0; div_r <= 32'd0;
      sa <= 32'd0; sb <= 32'd0; ss <= 1'b0;
      st_dly <= 0; st_left <= 0; st_arm <= 1'b0;
    end else if (div_start) begin
      sa <= div_a; sb <= div_b; ss <= div_symbol;
      st_dly <= cfg_dly; st_left <= cfg_len; st_arm <= 1'b1;
    end else if (st_arm) begin
      if (st_dly == 0) begin
        div_busy <= 1'b1; st_arm <= 1'b0;
      end else begin
        st_dly <= st_dly - 1;
      end
    end else if (div_busy && !hang) begin
      if (st_left <= 1) begin
        div_busy <= 1'b0;
        div_q <= (ss && (sa[31] ^ sb[31])) ? -qm : qm;
        div_r <= (ss && sa[31]) ? -rm : rm;
      end else begin
        st_left <= st_left - 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every res_valid and checks operand stability.
  always @(negedge clock) begin
    exp_t e;
    if (resetn) begin
      if (div_start) n_start++;
      if (prev_busy && !div_busy) fall_cyc = cyc;
      if (div_busy) begin
        chk("div_ab_stable", {div_a, div_b}, {sa, sb});
        chk("div_symbol_stable", {63'd0, div_symbol}, {63'd0, ss});
      end
      if (res_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_res_valid", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("res_hi", {32'd0, res_hi}, {32'd0, e.hi});
          chk("res_lo", {32'd0, res_lo}, {32'd0, e.lo});
          chk("stall_in_done", {63'd0, stall}, 64'd0);
          if (e.cyc >= 0) chk("bypass_latency", 64'(cyc), 64'(e.cyc));
          else            chk("run_latency", 64'(cyc), 64'(fall_cyc + 1));
        end
      end
    end
    prev_busy = resetn ? div_busy : 1'b0;
  end

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output bit byp);
    byp = 1'b1;
    if (b == 32'd0) begin
      hi = a; lo = 32'hFFFF_FFFF;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      hi = 32'd0; lo = 32'h8000_0000;
    end else begin
      byp = 1'b0;
      if (s) begin
        lo = $signed(a) / $signed(b);
        hi = $signed(a) % $signed(b);
      end else begin
        lo = a / b;
        hi = a % b;
      end
    end
  endfunction

  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit use_lit, input logic [31:0] lhi, input logic [31:0] llo);
    exp_t e;
    logic [31:0] mh, ml;
    bit byp;
    int st0, n;
    @(posedge clock); #1;
    req_a = a; req_b = b; req_signed = s; req_valid = 1'b1;
    ref_div(a, b, s, mh, ml, byp);
    e.hi  = use_lit ? lhi : mh;
    e.lo  = use_lit ? llo : ml;
    e.cyc = byp ? cyc + 1 : -1;
    sb_q.push_back(e);
    st0 = n_start;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (stall && n < 200);
    req_valid = 1'b0;
    chk("req_completes", 64'(n < 200), 64'd1);
    @(posedge clock); #1;
    chk("div_start_pulses", 64'(n_start - st0), byp ? 64'd0 : 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] a, b;
    logic s;
    resetn = 1'b0; req_valid = 1'b1; req_signed = 1'b0; flush = 1'b0;
    req_a = 32'd0; req_b = 32'd0;
    #1;
    chk("reset_stall", {63'd0, stall}, 64'd0);
    chk("reset_outs", {59'd0, res_valid, div_start, div_symbol, err_timeout, 1'b0}, 64'd0);
    chk("reset_data", {res_hi, res_lo}, 64'd0);
    chk("reset_opnd", {div_a, div_b}, 64'd0);
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;

    // Directed cases: unsigned, signed, divide-by-zero, signed overflow.
    cfg_dly = 1; cfg_len = 3;
    run_req(32'h8000_0000, 32'h7D5F_8A74, 1'b0, 1'b1, 32'h02A0_758C, 32'd1);
    run_req(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_req(32'd5, 32'd0, 1'b0, 1'b1, 32'd5, 32'hFFFF_FFFF);
    run_req(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'h8000_0000);

    // Flush in IDLE blocks capture of a would-be bypass request.
    @(posedge clock); #1;
    req_valid = 1'b1; req_a = 32'd5; req_b = 32'd0; flush = 1'b1;
    @(negedge clock) chk("idle_flush_stall", {63'd0, stall}, 64'd0);
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock) chk("idle_flush_nocap", {62'd0, res_valid, div_start}, 64'd0);

    // Flush in DONE suppresses the HI/LO write.
    @(posedge clock); #1;
    req_valid = 1'b1; req_a = 32'd9; req_b = 32'd0;
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clock) chk("done_flush_res_valid", {63'd0, res_valid}, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0;

    // Flush mid-RUN drains the divider without a result.
    cfg_dly = 0; cfg_len = 12;
    @(posedge clock); #1;
    req_valid = 1'b1; req_a = 32'd1000; req_b = 32'd7; req_signed = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!div_busy && n < 20) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("drain_stall", {63'd0, stall}, 64'd1);
    n = 0;
    while (stall && n < 50) begin @(posedge clock); #1; n++; end
    chk("drain_exit", 64'(n < 50), 64'd1);
    chk("drain_exit_busy", {63'd0, div_busy}, 64'd0);
    cfg_len = 2;
    run_req(32'd1000, 32'd7, 1'b0, 1'b1, 32'd6, 32'd142);

    // Hung divider: timeout after 63 counted cycles, then DRAIN until release.
    hang = 1'b1; cfg_dly = 0; cfg_len = 2;
    @(posedge clock); #1;
    req_valid = 1'b1; req_a = 32'd100; req_b = 32'd7; req_signed = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (64) @(posedge clock);
    @(negedge clock) chk("timeout_not_early", {63'd0, err_timeout}, 64'd0);
    @(posedge clock);
    @(negedge clock) chk("timeout_set", {63'd0, err_timeout}, 64'd1);
    chk("timeout_drain_stall", {63'd0, stall}, 64'd1);
    repeat (3) @(posedge clock);
    #1 hang = 1'b0;
    n = 0;
    while (stall && n < 50) begin @(posedge clock); #1; n++; end
    chk("timeout_drain_exit", 64'(n < 50), 64'd1);
    run_req(32'd77, 32'd10, 1'b0, 1'b1, 32'd7, 32'd7);
    chk("timeout_sticky", {63'd0, err_timeout}, 64'd1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      cfg_dly = $urandom_range(0, 2);
      cfg_len = $urandom_range(1, 6);
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
        2: b = 32'($urandom_range(1, 16));
        3: b = 32'hFFFF_FFFF;
        default: b = b;
      endcase
      run_req(a, b, s, 1'b0, 32'd0, 32'd0);
    end

    // Asynchronous reset during RUN discards the operation.
    cfg_dly = 0; cfg_len = 12;
    @(posedge clock); #1;
    req_valid = 1'b1; req_a = 32'd1000; req_b = 32'd3; req_signed = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!div_busy && n < 20) begin @(posedge clock); #1; n++; end
    @(posedge clock); #2;
    resetn = 1'b0;
    #1;
    chk("arst_ctrl", {60'd0, stall, res_valid, div_start, div_symbol}, 64'd0);
    chk("arst_err", {63'd0, err_timeout}, 64'd0);
    chk("arst_data", {res_hi, res_lo}, 64'd0);
    chk("arst_opnd", {div_a, div_b}, 64'd0);
    @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    repeat (15) @(posedge clock);
    cfg_len = 2;
    run_req(32'hFFFF_FFF0, 32'd3, 1'b1, 1'b0, 32'd0, 32'd0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
